// File: rtl/iocontroller_mc.sv
// -----------------------------------------------------------------------------
// iocontroller_mc
// Multi-channel syscall I/O controller. When the core executes SYSCALL (runio)
// the code in acc is decoded into HALT, LOAD(ch) or STORE(ch). LOAD/STORE run
// a 4-phase req/ack handshake on one of NCHAN peripheral channels and signal
// completion to the core with a one-cycle io_done pulse.
//
// Code map: 0 = HALT, 2k+1 = LOAD ch k, 2k+2 = STORE ch k (k < NCHAN),
// anything else is illegal (sets sticky io_err, completes as a no-op).
//
// Ports:
//   clock      in   1        clock
//   reset      in   1        asynchronous, active-low
//   runio      in   1        core is executing SYSCALL
//   acc        in   DATA_W   syscall code
//   io_ack     in   NCHAN    per-channel acknowledge
//   io_read    out  NCHAN    per-channel read request (one-hot or zero)
//   io_write   out  NCHAN    per-channel write request (one-hot or zero)
//   acc_write  out  1        load data valid, core writes acc this cycle
//   io_done    out  1        one-cycle completion pulse
//   halted     out  1        HALT syscall executed
//   io_err     out  1        sticky illegal-code / timeout flag
//
// Optional feature: define IOC_TIMEOUT_EN to abort a request that is not
// acknowledged within TMO_CYC cycles. Without it WAITACK waits forever.
// -----------------------------------------------------------------------------
module iocontroller_mc #(
  parameter int DATA_W  = 16,
  parameter int NCHAN   = 2,
  parameter int TMO_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              runio,
  input  logic [DATA_W-1:0] acc,
  input  logic [NCHAN-1:0]  io_ack,
  output logic [NCHAN-1:0]  io_read,
  output logic [NCHAN-1:0]  io_write,
  output logic              acc_write,
  output logic              io_done,
  output logic              halted,
  output logic              io_err
);

  localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef enum logic [1:0] {
    S_DECODE    = 2'd0,
    S_WAITACK   = 2'd1,
    S_WAITREADY = 2'd2,
    S_HALT      = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [CH_W-1:0]   ch_q;
  logic              op_load_q;
  logic              halted_q;
  logic              err_q;
  logic              done_q;

  logic [DATA_W-1:0] acc_m1;
  logic [DATA_W-1:0] code_ch;
  logic              code_halt;
  logic              code_io;
  logic [CH_W-1:0]   dec_ch;
  logic [NCHAN-1:0]  dec_sel;
  logic [NCHAN-1:0]  ch_sel;
  logic              ack_hit;
  logic              start;

  logic [NCHAN-1:0]  read_c;
  logic [NCHAN-1:0]  write_c;
  logic              acc_write_c;
  logic              latch_req;
  logic              set_err;
  logic              set_halt;
  logic              set_done;

  // Channel index is (acc-1)>>1 over the full acc width, so any nonzero
  // upper bits push it out of range and the code is treated as illegal.
  assign acc_m1    = acc - DATA_W'(1);
  assign code_ch   = acc_m1 >> 1;
  assign code_halt = (acc == '0);
  assign code_io   = !code_halt && (code_ch < DATA_W'(NCHAN));
  assign dec_ch    = code_ch[CH_W-1:0];
  assign dec_sel   = NCHAN'(1) << dec_ch;
  assign ch_sel    = NCHAN'(1) << ch_q;

  // Only the latched channel's ack bit is looked at.
  assign ack_hit   = |(io_ack & ch_sel);

  // In the io_done cycle the core still holds runio for the syscall that
  // just finished; it must not be decoded a second time.
  assign start     = runio && !done_q;

`ifdef IOC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != S_WAITACK) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`endif

  always_comb begin
    next_state  = state;
    read_c      = '0;
    write_c     = '0;
    acc_write_c = 1'b0;
    latch_req   = 1'b0;
    set_err     = 1'b0;
    set_halt    = 1'b0;
    set_done    = 1'b0;
    case (state)
      S_DECODE: begin
        if (start) begin
          if (code_halt) begin
            set_halt   = 1'b1;
            next_state = S_HALT;
          end else if (code_io) begin
            // Zero-latency request straight from the decoder.
            if (acc[0]) read_c  = dec_sel;
            else        write_c = dec_sel;
            latch_req  = 1'b1;
            next_state = S_WAITACK;
          end else begin
            set_err  = 1'b1;
            set_done = 1'b1;
          end
        end
      end
      S_WAITACK: begin
        if (op_load_q) read_c  = ch_sel;
        else           write_c = ch_sel;
        if (ack_hit) begin
          acc_write_c = runio && op_load_q;
          set_done    = 1'b1;
          next_state  = S_WAITREADY;
        end
`ifdef IOC_TIMEOUT_EN
        else if (tmo_hit) begin
          set_err    = 1'b1;
          set_done   = 1'b1;
          next_state = S_DECODE;
        end
`endif
      end
      S_WAITREADY: begin
        if (!ack_hit) next_state = S_DECODE;
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_DECODE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_DECODE;
      ch_q      <= '0;
      op_load_q <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= set_done;
      if (latch_req) begin
        ch_q      <= dec_ch;
        op_load_q <= acc[0];
      end
      if (set_halt) halted_q <= 1'b1;
      if (set_err)  err_q    <= 1'b1;
    end
  end

  // The decode path is combinational from inputs, so it is masked while
  // reset is held to keep every request low during reset.
  assign io_read   = reset ? read_c  : '0;
  assign io_write  = reset ? write_c : '0;
  assign acc_write = reset && acc_write_c;
  assign io_done   = done_q;
  assign halted    = halted_q;
  assign io_err    = err_q;

endmodule
